// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Purpose  : Groups the M-stage request/response handshake and the data-bus
//             req/ack signals of the load/store unit.
//  Ports    : none (signal bundle only)
//             slave  modport - the load/store unit's view
//             master modport - the environment (pipeline + bus) view
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int DATA_W = 32
) ();
  // M-stage request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic                  req_addr_ov;
  logic [DATA_W-1:0]     req_wdata;
  // data bus
  logic                  m_req;
  logic                  m_we;
  logic [31:0]           m_addr;
  logic [DATA_W/8-1:0]   m_byteen;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_ack;
  logic [DATA_W-1:0]     m_rdata;
  // response to the pipeline
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic [1:0]            resp_exc;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_addr_ov,
           req_wdata, m_ack, m_rdata,
    output req_ready, m_req, m_we, m_addr, m_byteen, m_wdata,
           resp_valid, resp_rdata, resp_exc
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_addr_ov,
           req_wdata, m_ack, m_rdata,
    input  req_ready, m_req, m_we, m_addr, m_byteen, m_wdata,
           resp_valid, resp_rdata, resp_exc
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Load/store unit between the M-stage and the data bus. Checks
//             alignment and the address map (AdEL/AdES), drives byte enables
//             and lane-shifted store data, runs a req/ack bus cycle with a
//             wait-state timeout and returns aligned, extended load data.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous reset, active-low
//             bus   - mem_access_unit_if.slave (request, bus, response)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] DM_SIZE   = 32'h3000,
  parameter logic [31:0] DEV0_BASE = 32'h7F00,
  parameter logic [31:0] DEV1_BASE = 32'h7F10,
  parameter logic [31:0] DEV2_BASE = 32'h7F20,
  parameter int          TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);
  localparam int c_nb    = DATA_W / 8;
  localparam int c_ofs   = $clog2(c_nb);
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_bus  = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  localparam logic [1:0] c_exc_none = 2'd0;
  localparam logic [1:0] c_exc_adel = 2'd1;
  localparam logic [1:0] c_exc_ades = 2'd2;
  localparam logic [1:0] c_exc_tmo  = 2'd3;

  logic [1:0]         r_state, w_next_state;
  logic               w_req_ready, w_m_req, w_resp_fire, w_accept, w_wait_done;

  logic               r_we, r_unsigned;
  logic [1:0]         r_size;
  logic [c_ofs-1:0]   r_lane;
  logic [31:0]        r_addr;
  logic [c_nb-1:0]    r_byteen;
  logic [DATA_W-1:0]  r_wdata;
  logic [1:0]         r_exc;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic [DATA_W-1:0]  r_rdata_raw;
  logic               r_resp_valid;
  logic [DATA_W-1:0]  r_resp_rdata;
  logic [1:0]         r_resp_exc;

  logic [c_ofs-1:0]   w_lane;
  logic [c_nb-1:0]    w_size_mask, w_byteen;
  logic               w_misalign, w_bad_size, w_in_dm, w_in_dev0, w_in_dev1, w_in_dev2;
  logic               w_in_dev, w_in_cnt, w_exc;
  logic [DATA_W-1:0]  w_shifted, w_load;
  logic               w_sign, w_fill;

  // ---------------- request decode (evaluated in the accept cycle) ----------
  always_comb begin
    w_lane      = bus.req_addr[c_ofs-1:0];
    w_size_mask = '0;
    for (int i = 0; i < c_nb; i++) w_size_mask[i] = (i < (1 << bus.req_size));
    w_byteen    = w_size_mask << w_lane;

    w_misalign = ((bus.req_size >= 2'd1) && bus.req_addr[0]) ||
                 ((bus.req_size >= 2'd2) && bus.req_addr[1]) ||
                 ((bus.req_size == 2'd3) && bus.req_addr[2]);
    w_bad_size = (bus.req_size == 2'd3) && (DATA_W == 32);
    w_in_dm    = bus.req_addr < DM_SIZE;
    w_in_dev0  = (bus.req_addr >= DEV0_BASE) && (bus.req_addr < DEV0_BASE + 32'd12);
    w_in_dev1  = (bus.req_addr >= DEV1_BASE) && (bus.req_addr < DEV1_BASE + 32'd12);
    w_in_dev2  = (bus.req_addr >= DEV2_BASE) && (bus.req_addr < DEV2_BASE + 32'd4);
    w_in_dev   = w_in_dev0 || w_in_dev1 || w_in_dev2;
    // timer count words live at +8..+11 of each timer window
    w_in_cnt   = ((bus.req_addr >= DEV0_BASE + 32'd8) && (bus.req_addr < DEV0_BASE + 32'd12)) ||
                 ((bus.req_addr >= DEV1_BASE + 32'd8) && (bus.req_addr < DEV1_BASE + 32'd12));
    w_exc      = w_misalign || w_bad_size || bus.req_addr_ov ||
                 !(w_in_dm || w_in_dev) ||
                 (w_in_dev && (bus.req_size != 2'd2)) ||
                 (bus.req_store && w_in_cnt);
  end

  // ---------------- load data alignment and extension -----------------------
  always_comb begin
    w_shifted = r_rdata_raw >> {r_lane, 3'b000};
    case (r_size)
      2'd0:    w_sign = w_shifted[7];
      2'd1:    w_sign = w_shifted[15];
      2'd2:    w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase
    w_fill = w_sign & ~r_unsigned;
    w_load = '0;
    for (int i = 0; i < DATA_W; i++) w_load[i] = (i < (8 << r_size)) ? w_shifted[i] : w_fill;
  end

  // ---------------- FSM: state register -------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // ---------------- FSM: next state -----------------------------------------
  // The ack is checked first so an ack coinciding with the last wait cycle wins.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_next_state = w_exc ? c_st_resp : c_st_bus;
      c_st_bus:  if (bus.m_ack || w_wait_done) w_next_state = c_st_resp;
      c_st_resp: w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // ---------------- FSM: outputs --------------------------------------------
  // m_req decodes the state register, so an asynchronous reset drops it at once.
  always_comb begin
    w_req_ready = (r_state == c_st_idle);
    w_m_req     = (r_state == c_st_bus);
    w_resp_fire = (r_state == c_st_resp);
    w_accept    = bus.req_valid && w_req_ready;
    w_wait_done = w_m_req && !bus.m_ack && (r_wait_cnt == c_wait_last);
  end

  // ---------------- datapath registers --------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'd0;
      r_lane       <= '0;
      r_addr       <= '0;
      r_byteen     <= '0;
      r_wdata      <= '0;
      r_exc        <= c_exc_none;
      r_wait_cnt   <= '0;
      r_rdata_raw  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_exc   <= c_exc_none;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_we       <= bus.req_store;
        r_unsigned <= bus.req_unsigned;
        r_size     <= bus.req_size;
        r_lane     <= w_lane;
        r_addr     <= {bus.req_addr[31:c_ofs], {c_ofs{1'b0}}};
        r_byteen   <= bus.req_store ? w_byteen : '0;
        r_wdata    <= bus.req_wdata << {w_lane, 3'b000};
        r_exc      <= !w_exc ? c_exc_none : (bus.req_store ? c_exc_ades : c_exc_adel);
        r_wait_cnt <= '0;
      end
      if (w_m_req) begin
        if (bus.m_ack) begin
          r_rdata_raw <= bus.m_rdata;
        end else begin
          r_wait_cnt <= r_wait_cnt + c_cnt_one;
          if (r_wait_cnt == c_wait_last) r_exc <= c_exc_tmo;
        end
      end
      if (w_resp_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_exc   <= r_exc;
        r_resp_rdata <= (r_we || (r_exc != c_exc_none)) ? '0 : w_load;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.m_req      = w_m_req;
  assign bus.m_we       = r_we;
  assign bus.m_addr     = r_addr;
  assign bus.m_byteen   = r_byteen;
  assign bus.m_wdata    = r_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_exc   = r_resp_exc;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Scoreboard testbench for mem_access_unit, 32- and 64-bit builds.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  typedef struct {
    logic [1:0]  exc;
    logic [63:0] rdata;
    int          lat;
    time         acc;
  } resp_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  byteen;
    logic [63:0] wdata;
  } bus_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  resp_t rq32[$];
  resp_t rq64[$];
  bus_t  bq32[$];
  bus_t  bq64[$];

  int          ack_delay32 = -1;
  logic [31:0] rdata32     = '0;
  logic [63:0] rdata64     = '0;
  int          wc32        = 0;
  int          req_hi32    = 0;
  logic        prev_req32  = 1'b0;
  logic        prev_req64  = 1'b0;

  mem_access_unit_if #(.DATA_W(32)) bif ();
  mem_access_unit_if #(.DATA_W(64)) bif64 ();

  mem_access_unit #(.DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bif));
  mem_access_unit #(.DATA_W(64)) dut64 (.clk(clk), .reset(reset), .bus(bif64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus responders ------------------------------------------
  initial begin
    bif.m_ack = 1'b0;
    bif.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bif.m_req) begin
        bif.m_ack   = (ack_delay32 >= 0) && (wc32 == ack_delay32);
        bif.m_rdata = rdata32;
        wc32++;
        req_hi32++;
      end else begin
        bif.m_ack = 1'b0;
        wc32      = 0;
      end
    end
  end

  initial begin
    bif64.m_ack = 1'b0;
    bif64.m_rdata = '0;
    forever begin
      @(negedge clk);
      bif64.m_ack   = bif64.m_req;
      bif64.m_rdata = rdata64;
    end
  end

  // ---------------- monitors -------------------------------------------------
  initial begin
    bus_t  b;
    resp_t r;
    forever begin
      @(negedge clk);
      if (bif.m_req && !prev_req32) begin
        if (bq32.size() == 0) chk("u32 unexpected bus cycle", 1, 0);
        else begin
          b = bq32.pop_front();
          chk("u32 m_we", bif.m_we, b.we);
          chk("u32 m_addr", bif.m_addr, b.addr);
          chk("u32 m_byteen", bif.m_byteen, b.byteen);
          chk("u32 m_wdata", bif.m_wdata, b.wdata);
        end
      end
      prev_req32 = bif.m_req;
      if (bif.resp_valid) begin
        if (rq32.size() == 0) chk("u32 unexpected resp_valid", 1, 0);
        else begin
          r = rq32.pop_front();
          chk("u32 resp_exc", bif.resp_exc, r.exc);
          chk("u32 resp_rdata", bif.resp_rdata, r.rdata);
          chk("u32 latency", int'(($time - r.acc + 5) / 10), r.lat);
        end
      end
    end
  end

  initial begin
    bus_t  b;
    resp_t r;
    forever begin
      @(negedge clk);
      if (bif64.m_req && !prev_req64) begin
        if (bq64.size() == 0) chk("u64 unexpected bus cycle", 1, 0);
        else begin
          b = bq64.pop_front();
          chk("u64 m_we", bif64.m_we, b.we);
          chk("u64 m_addr", bif64.m_addr, b.addr);
          chk("u64 m_byteen", bif64.m_byteen, b.byteen);
          chk("u64 m_wdata", bif64.m_wdata, b.wdata);
        end
      end
      prev_req64 = bif64.m_req;
      if (bif64.resp_valid) begin
        if (rq64.size() == 0) chk("u64 unexpected resp_valid", 1, 0);
        else begin
          r = rq64.pop_front();
          chk("u64 resp_exc", bif64.resp_exc, r.exc);
          chk("u64 resp_rdata", bif64.resp_rdata, r.rdata);
          chk("u64 latency", int'(($time - r.acc + 5) / 10), r.lat);
        end
      end
    end
  end

  // ---------------- drivers -------------------------------------------------
  task automatic issue32(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] addr, input logic ov, input logic [31:0] wd,
                         input int delay, input logic [31:0] rd,
                         input logic [1:0] eexc, input logic [31:0] erd, input int elat,
                         input logic [31:0] eaddr, input logic [3:0] ebe,
                         input logic [31:0] ewd, input bit wait_resp);
    resp_t r;
    bus_t  b;
    ack_delay32 = delay;
    rdata32     = rd;
    req_hi32    = 0;
    if (eexc == 2'd0 || eexc == 2'd3) begin
      b.we = st; b.addr = eaddr; b.byteen = {4'b0, ebe}; b.wdata = {32'b0, ewd};
      bq32.push_back(b);
    end
    @(negedge clk);
    bif.req_store = st; bif.req_size = sz; bif.req_unsigned = un;
    bif.req_addr = addr; bif.req_addr_ov = ov; bif.req_wdata = wd;
    bif.req_valid = 1'b1;
    for (int k = 0; k < 50 && !bif.req_ready; k++) @(negedge clk);
    if (!bif.req_ready) chk("u32 req_ready wait", 0, 1);
    @(posedge clk);
    r.exc = eexc; r.rdata = {32'b0, erd}; r.lat = elat; r.acc = $time;
    rq32.push_back(r);
    #1 bif.req_valid = 1'b0;
    if (wait_resp) begin
      for (int k = 0; k < 100 && rq32.size() != 0; k++) @(negedge clk);
      if (rq32.size() != 0) begin
        chk("u32 response wait", rq32.size(), 0);
        rq32.delete();
      end
    end
  endtask

  // Address exception: no bus cycle, response two cycles after accept.
  task automatic exc32(input logic st, input logic [1:0] sz, input logic [31:0] addr,
                       input logic ov);
    issue32(st, sz, 1'b0, addr, ov, 32'h5A5A_5A5A, 0, 32'h0,
            st ? 2'd2 : 2'd1, 32'h0, 2, 32'h0, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic issue64(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input logic [1:0] eexc, input logic [63:0] erd, input int elat,
                         input logic [31:0] eaddr, input logic [7:0] ebe,
                         input logic [63:0] ewd);
    resp_t r;
    bus_t  b;
    rdata64 = rd;
    if (eexc == 2'd0) begin
      b.we = st; b.addr = eaddr; b.byteen = ebe; b.wdata = ewd;
      bq64.push_back(b);
    end
    @(negedge clk);
    bif64.req_store = st; bif64.req_size = sz; bif64.req_unsigned = un;
    bif64.req_addr = addr; bif64.req_addr_ov = 1'b0; bif64.req_wdata = wd;
    bif64.req_valid = 1'b1;
    for (int k = 0; k < 50 && !bif64.req_ready; k++) @(negedge clk);
    if (!bif64.req_ready) chk("u64 req_ready wait", 0, 1);
    @(posedge clk);
    r.exc = eexc; r.rdata = erd; r.lat = elat; r.acc = $time;
    rq64.push_back(r);
    #1 bif64.req_valid = 1'b0;
    for (int k = 0; k < 100 && rq64.size() != 0; k++) @(negedge clk);
    if (rq64.size() != 0) begin
      chk("u64 response wait", rq64.size(), 0);
      rq64.delete();
    end
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    reset = 1'b0;
    bif.req_valid = 1'b0; bif.req_store = 1'b0; bif.req_size = 2'd0;
    bif.req_unsigned = 1'b0; bif.req_addr = '0; bif.req_addr_ov = 1'b0; bif.req_wdata = '0;
    bif64.req_valid = 1'b0; bif64.req_store = 1'b0; bif64.req_size = 2'd0;
    bif64.req_unsigned = 1'b0; bif64.req_addr = '0; bif64.req_addr_ov = 1'b0; bif64.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", bif.req_ready, 1);
    chk("reset m_req", bif.m_req, 0);
    chk("reset m_we", bif.m_we, 0);
    chk("reset m_byteen", bif.m_byteen, 0);
    chk("reset m_wdata", bif.m_wdata, 0);
    chk("reset resp_valid", bif.resp_valid, 0);
    chk("reset resp_rdata", bif.resp_rdata, 0);
    chk("reset resp_exc", bif.resp_exc, 0);
    reset = 1'b1;
    @(negedge clk);

    // stores and loads on data memory
    issue32(1, 0, 0, 32'h1003, 0, 32'hAB, 0, 0, 0, 0, 3, 32'h1000, 4'b1000, 32'hAB00_0000, 1);
    issue32(0, 1, 0, 32'h0002, 0, 0, 0, 32'h8001_1234, 0, 32'hFFFF_8001, 3, 32'h0, 4'h0, 32'h0, 1);
    repeat (2) @(negedge clk);
    chk("hold resp_valid", bif.resp_valid, 0);
    chk("hold resp_rdata", bif.resp_rdata, 32'hFFFF_8001);
    issue32(0, 1, 1, 32'h0002, 0, 0, 0, 32'h8001_1234, 0, 32'h0000_8001, 3, 32'h0, 4'h0, 32'h0, 1);
    issue32(0, 0, 0, 32'h0001, 0, 0, 0, 32'h1234_8056, 0, 32'hFFFF_FF80, 3, 32'h0, 4'h0, 32'h0, 1);
    issue32(0, 0, 1, 32'h0003, 0, 0, 0, 32'hF100_0000, 0, 32'h0000_00F1, 3, 32'h0, 4'h0, 32'h0, 1);
    issue32(1, 1, 0, 32'h0102, 0, 32'h1234_BEEF, 2, 0, 0, 0, 5, 32'h0100, 4'b1100, 32'hBEEF_0000, 1);
    issue32(0, 2, 0, 32'h2FFC, 0, 0, 0, 32'h1122_3344, 0, 32'h1122_3344, 3, 32'h2FFC, 4'h0, 32'h0, 1);

    // device windows
    issue32(1, 2, 0, 32'h7F20, 0, 32'h1, 1, 0, 0, 0, 4, 32'h7F20, 4'b1111, 32'h1, 1);
    issue32(0, 2, 0, 32'h7F18, 0, 0, 0, 32'h0ABC, 0, 32'h0ABC, 3, 32'h7F18, 4'h0, 32'h0, 1);
    issue32(1, 2, 0, 32'h7F14, 0, 32'h77, 0, 0, 0, 0, 3, 32'h7F14, 4'b1111, 32'h77, 1);

    // address exceptions
    exc32(1, 2, 32'h7F08, 0);
    exc32(0, 1, 32'h7F00, 0);
    exc32(0, 2, 32'h3000, 0);
    exc32(0, 2, 32'h0002, 0);
    exc32(1, 1, 32'h0001, 0);
    exc32(0, 3, 32'h0000, 0);
    exc32(0, 2, 32'h0010, 1);
    exc32(0, 2, 32'h7F0C, 0);
    exc32(1, 2, 32'h7F18, 0);

    // timeout and ack on the last wait cycle
    issue32(0, 2, 0, 32'h0004, 0, 0, -1, 32'hFFFF_FFFF, 3, 0, 18, 32'h0004, 4'h0, 32'h0, 1);
    chk("timeout m_req cycles", req_hi32, 16);
    issue32(0, 2, 0, 32'h0004, 0, 0, 15, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 18, 32'h0004, 4'h0, 32'h0, 1);
    chk("late ack m_req cycles", req_hi32, 16);

    // reset while the bus cycle is outstanding
    issue32(0, 2, 0, 32'h0040, 0, 0, -1, 0, 3, 0, 18, 32'h0040, 4'h0, 32'h0, 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("reset mid-bus m_req", bif.m_req, 0);
    rq32.delete();
    @(negedge clk);
    reset = 1'b1;
    #1 chk("after reset req_ready", bif.req_ready, 1);
    repeat (20) @(negedge clk);
    chk("after reset resp_valid", bif.resp_valid, 0);

    // 64-bit build
    issue64(1, 3, 0, 32'h0008, 64'h0102_0304_0506_0708, 0, 0, 0, 3,
            32'h0008, 8'hFF, 64'h0102_0304_0506_0708);
    issue64(0, 3, 0, 32'h0004, 0, 0, 1, 0, 2, 32'h0, 8'h0, 64'h0);
    issue64(0, 2, 0, 32'h0004, 0, 64'h89AB_CDEF_0123_4567, 0, 64'hFFFF_FFFF_89AB_CDEF, 3,
            32'h0000, 8'h00, 64'h0);
    issue64(0, 2, 1, 32'h0004, 0, 64'h89AB_CDEF_0123_4567, 0, 64'h0000_0000_89AB_CDEF, 3,
            32'h0000, 8'h00, 64'h0);
    issue64(1, 2, 0, 32'h000C, 64'hCAFE_BABE, 0, 0, 0, 3,
            32'h0008, 8'hF0, 64'hCAFE_BABE_0000_0000);
    issue64(0, 3, 0, 32'h0010, 0, 64'h8000_0000_0000_0001, 0, 64'h8000_0000_0000_0001, 3,
            32'h0010, 8'h00, 64'h0);
    issue64(0, 0, 0, 32'h0007, 0, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 3,
            32'h0000, 8'h00, 64'h0);

    repeat (3) @(negedge clk);
    chk("u32 leftover bus expectations", bq32.size(), 0);
    chk("u64 leftover bus expectations", bq64.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
